// File: rtl/pwm_ramp_ctrl_pkg.sv
// Shared definitions for the PWM ramp controller: FSM state encoding,
// default parameter values and the full-scale duty helper.
package pwm_ramp_ctrl_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DEFAULT_R         = 8;
    localparam int DEFAULT_HOLD_BITS = 8;

    // Duty value that means 100 % for a generator of resolution r.
    function automatic int full_scale(input int r);
        return 1 << r;
    endfunction

endpackage

// File: rtl/pwm_ramp_ctrl.sv
// Slew-rate limiter / soft-start sequencer for one PWM channel.
// Walks the committed duty toward the goal in bounded steps, one step every
// hold_periods+1 loads accepted by the PWM generator.
module pwm_ramp_ctrl
    import pwm_ramp_ctrl_pkg::*;
#(
    parameter int R         = DEFAULT_R,
    parameter int HOLD_BITS = DEFAULT_HOLD_BITS
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic [R:0]           target_duty,
    input  logic [R:0]           step_size,
    input  logic [HOLD_BITS-1:0] hold_periods,
    input  logic                 kill,
    input  logic                 pwm_done,
    output logic [R:0]           pwm_duty,
    output logic                 pwm_ready,
    output logic [R:0]           cur_duty,
    output logic                 busy,
    output logic                 at_target
);

    localparam int               DUTY_W     = R + 1;
    localparam logic [DUTY_W-1:0] FULL_SCALE = DUTY_W'(full_scale(R));

    state_t               state;
    state_t               state_nxt;
    logic [DUTY_W-1:0]    goal;
    logic [DUTY_W-1:0]    cur_new;
    logic [DUTY_W-1:0]    step_base;
    logic [DUTY_W-1:0]    step_s;
    logic [DUTY_W-1:0]    step_d;
    logic [DUTY_W-1:0]    step_val;
    logic [DUTY_W-1:0]    duty_nxt;
    logic [HOLD_BITS-1:0] hold_cnt;
    logic [HOLD_BITS-1:0] hold_nxt;
    logic                 at_target_nxt;

    // Goal selection and the next step toward it, clamped so it never overshoots.
    always_comb begin
        goal      = kill ? '0 : target_duty;
        cur_new   = pwm_done ? pwm_duty : cur_duty;
        step_base = (state == RUN) ? pwm_duty : cur_duty;
        step_s    = kill ? FULL_SCALE
                         : ((step_size == '0) ? DUTY_W'(1) : step_size);
        step_d    = '0;
        step_val  = goal;
        if (goal >= step_base) begin
            step_d   = goal - step_base;
            step_val = (step_d <= step_s) ? goal : step_base + step_s;
        end else begin
            step_d   = step_base - goal;
            step_val = (step_d <= step_s) ? goal : step_base - step_s;
        end
    end

    // Next-state logic: start a ramp, hold each duty for the programmed number of
    // loads, stop on reaching the goal or when enable drops without kill.
    always_comb begin
        state_nxt     = state;
        duty_nxt      = pwm_duty;
        hold_nxt      = hold_cnt;
        at_target_nxt = 1'b0;
        unique case (state)
            IDLE: begin
                if ((enable && (goal != cur_duty)) || kill) begin
                    state_nxt = RUN;
                    duty_nxt  = step_val;
                    hold_nxt  = '0;
                end
            end
            RUN: begin
                if (!enable && !kill) begin
                    state_nxt = IDLE;
                end else if (pwm_done) begin
                    if (cur_new == goal) begin
                        state_nxt     = IDLE;
                        at_target_nxt = 1'b1;
                    end else if (kill || (hold_cnt == hold_periods)) begin
                        hold_nxt = '0;
                        duty_nxt = step_val;
                    end else begin
                        hold_nxt = hold_cnt + HOLD_BITS'(1);
                    end
                end
            end
        endcase
    end

    // FSM state, presented duty, hold counter and the goal-reached pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            pwm_duty  <= '0;
            hold_cnt  <= '0;
            at_target <= 1'b0;
        end else begin
            state     <= state_nxt;
            pwm_duty  <= duty_nxt;
            hold_cnt  <= hold_nxt;
            at_target <= at_target_nxt;
        end
    end

    // Committed duty follows every load the generator accepts, in any state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_duty <= '0;
        end else if (pwm_done) begin
            cur_duty <= pwm_duty;
        end
    end

    assign pwm_ready = (state == RUN);
    assign busy      = (state == RUN) && (goal != cur_duty);

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Self-checking bench for pwm_ramp_ctrl: directed ramp scenarios plus a
// randomized run against a behavioural reference model.
module tb_pwm_ramp_ctrl;

    localparam int R         = 8;
    localparam int HOLD_BITS = 8;
    localparam int DUTY_W    = R + 1;
    localparam int FULL      = 1 << R;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic                 enable = 1'b0;
    logic [DUTY_W-1:0]    target_duty = '0;
    logic [DUTY_W-1:0]    step_size = '0;
    logic [HOLD_BITS-1:0] hold_periods = '0;
    logic                 kill = 1'b0;
    logic                 pwm_done = 1'b0;
    logic [DUTY_W-1:0]    pwm_duty;
    logic                 pwm_ready;
    logic [DUTY_W-1:0]    cur_duty;
    logic                 busy;
    logic                 at_target;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    bit m_run;
    int m_duty;
    int m_cur;
    int m_cnt;
    bit m_at;

    // PWM generator model and observation helpers
    int gen_period = 1;
    int gen_cnt    = 0;
    int loads[$];
    int at_count   = 0;

    pwm_ramp_ctrl #(.R(R), .HOLD_BITS(HOLD_BITS)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .target_duty  (target_duty),
        .step_size    (step_size),
        .hold_periods (hold_periods),
        .kill         (kill),
        .pwm_done     (pwm_done),
        .pwm_duty     (pwm_duty),
        .pwm_ready    (pwm_ready),
        .cur_duty     (cur_duty),
        .busy         (busy),
        .at_target    (at_target)
    );

    // free-running system clock
    always #5 clk = ~clk;

    // hard stop in case the bench itself stalls
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, actual, expected, $time);
        end
    endtask

    // move 'from' toward 'goal' by at most s, landing exactly on goal when close
    function automatic int stepToward(input int from, input int goal, input int s);
        int diff;
        diff = goal - from;
        if (diff <= s && diff >= -s) return goal;
        return (diff > 0) ? from + s : from - s;
    endfunction

    task automatic modelReset();
        m_run  = 1'b0;
        m_duty = 0;
        m_cur  = 0;
        m_cnt  = 0;
        m_at   = 1'b0;
    endtask

    task automatic modelUpdate(input bit en, input int tgt, input int stp,
                               input int hold, input bit kl, input bit done);
        int goal;
        int s;
        int accepted;
        bit reached;
        goal     = kl ? 0 : tgt;
        s        = kl ? FULL : ((stp == 0) ? 1 : stp);
        accepted = m_duty;
        reached  = 1'b0;
        if (!m_run) begin
            if ((en && goal != m_cur) || kl) begin
                m_run  = 1'b1;
                m_duty = stepToward(m_cur, goal, s);
                m_cnt  = 0;
            end
        end else if (!en && !kl) begin
            m_run = 1'b0;
        end else if (done) begin
            if (accepted == goal) begin
                m_run   = 1'b0;
                reached = 1'b1;
            end else if (kl || m_cnt == hold) begin
                m_cnt  = 0;
                m_duty = stepToward(accepted, goal, s);
            end else begin
                m_cnt = (m_cnt + 1) % (1 << HOLD_BITS);
            end
        end
        if (done) m_cur = accepted;
        m_at = reached;
    endtask

    task automatic checkAll();
        int goal;
        goal = kill ? 0 : int'(target_duty);
        checkOutput("pwm_duty", int'(pwm_duty), m_duty);
        checkOutput("pwm_ready", int'(pwm_ready), int'(m_run));
        checkOutput("cur_duty", int'(cur_duty), m_cur);
        checkOutput("busy", int'(busy), int'(m_run && (goal != m_cur)));
        checkOutput("at_target", int'(at_target), int'(m_at));
        if (at_target) at_count++;
    endtask

    // one clock: check outputs, drive new inputs and the generator's done pulse
    task automatic applyStimulus(input bit en, input int tgt, input int stp,
                                 input int hold, input bit kl);
        bit done;
        @(negedge clk);
        checkAll();
        enable       = en;
        target_duty  = DUTY_W'(tgt);
        step_size    = DUTY_W'(stp);
        hold_periods = HOLD_BITS'(hold);
        kill         = kl;
        done         = pwm_ready && (gen_cnt == 0);
        pwm_done     = done;
        if (done) loads.push_back(int'(pwm_duty));
        gen_cnt = (gen_cnt == 0) ? gen_period - 1 : gen_cnt - 1;
        @(posedge clk);
        modelUpdate(en, tgt, stp, hold, kl, done);
    endtask

    task automatic runUntilTarget(input string tag, input bit en, input int tgt,
                                  input int stp, input int hold, input bit kl,
                                  input int budget);
        int start;
        start = at_count;
        for (int i = 0; i < budget; i++) begin
            applyStimulus(en, tgt, stp, hold, kl);
            if (at_count != start) return;
        end
        checkOutput({tag, "_timeout"}, 0, 1);
    endtask

    task automatic checkLoads(input string tag, input int exp_q[$]);
        checkOutput({tag, "_count"}, loads.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < loads.size(); i++)
            checkOutput($sformatf("%s_load%0d", tag, i), loads[i], exp_q[i]);
    endtask

    // asynchronous reset landing between clock edges
    task automatic doReset(input string tag);
        @(posedge clk);
        #2;
        reset_n  = 1'b0;
        pwm_done = 1'b0;
        enable   = 1'b0;
        kill     = 1'b0;
        #1;
        checkOutput({tag, "_rst_duty"}, int'(pwm_duty), 0);
        checkOutput({tag, "_rst_ready"}, int'(pwm_ready), 0);
        checkOutput({tag, "_rst_cur"}, int'(cur_duty), 0);
        checkOutput({tag, "_rst_busy"}, int'(busy), 0);
        checkOutput({tag, "_rst_at"}, int'(at_target), 0);
        modelReset();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        int exp_q[$];
        int r_tgt;
        int r_stp;
        int r_hold;
        bit r_en;
        bit r_kill;

        modelReset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // reset mid-ramp, then no request while enable stays low
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 200, 10, 1, 1'b0);
        doReset("t1");
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 200, 10, 1, 1'b0);
        #1;
        checkOutput("t1_ready_idle", int'(pwm_ready), 0);

        // plain ramp with one step per period
        doReset("t2");
        loads.delete();
        at_count = 0;
        runUntilTarget("t2", 1'b1, 100, 25, 0, 1'b0, 50);
        exp_q = '{25, 50, 75, 100};
        checkLoads("t2", exp_q);
        applyStimulus(1'b1, 100, 25, 0, 1'b0);
        applyStimulus(1'b1, 100, 25, 0, 1'b0);
        checkOutput("t2_at_once", at_count, 1);
        checkOutput("t2_ready_drop", int'(pwm_ready), 0);

        // each duty held for three loads
        doReset("t3");
        loads.delete();
        runUntilTarget("t3", 1'b1, 10, 4, 2, 1'b0, 100);
        exp_q = '{4, 4, 4, 8, 8, 8, 10};
        checkLoads("t3", exp_q);

        // target lowered while 120 is pending: reverse without overshoot
        doReset("t4");
        loads.delete();
        for (int i = 0; i < 50; i++) begin
            applyStimulus(1'b1, 200, 30, 0, 1'b0);
            #1;
            if (pwm_duty == DUTY_W'(120)) break;
        end
        runUntilTarget("t4", 1'b1, 50, 30, 0, 1'b0, 50);
        exp_q = '{30, 60, 90, 120, 90, 60, 50};
        checkLoads("t4", exp_q);

        // full scale, then kill with enable low and a tiny step
        runUntilTarget("t5a", 1'b1, 256, 256, 0, 1'b0, 20);
        checkOutput("t5_full", int'(cur_duty), 256);
        loads.delete();
        runUntilTarget("t5", 1'b0, 256, 1, 0, 1'b1, 20);
        exp_q = '{0};
        checkLoads("t5", exp_q);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 256, 1, 0, 1'b0);
        checkOutput("t5_cur_zero", int'(cur_duty), 0);

        // zero step acts as one; enable dropped mid-ramp freezes the duty
        doReset("t6");
        loads.delete();
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 3, 0, 0, 1'b0);
            #1;
            if (pwm_duty == DUTY_W'(2)) break;
        end
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 3, 0, 0, 1'b0);
        #1;
        exp_q = '{1, 2};
        checkLoads("t6", exp_q);
        checkOutput("t6_duty_frozen", int'(pwm_duty), 2);
        checkOutput("t6_ready_low", int'(pwm_ready), 0);
        checkOutput("t6_busy_low", int'(busy), 0);

        // randomized traffic against the reference model
        doReset("rnd");
        r_en = 1'b1; r_tgt = 128; r_stp = 10; r_hold = 0; r_kill = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                r_en   = ($urandom_range(0, 9) != 0);
                r_tgt  = $urandom_range(0, FULL);
                r_stp  = $urandom_range(0, 60);
                r_hold = $urandom_range(0, 3);
                r_kill = ($urandom_range(0, 19) == 0);
            end
            if ($urandom_range(0, 49) == 0) gen_period = $urandom_range(1, 4);
            if ($urandom_range(0, 299) == 0) doReset("rnd");
            applyStimulus(r_en, r_tgt, r_stp, r_hold, r_kill);
        end
        @(negedge clk);
        checkAll();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
